// File: rtl/compute_ip_arbiter_pkg.sv
// Shared types for the compute IP arbiter: FSM states and sticky error bit positions.
package compute_ip_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } ArbState_t;

    typedef enum logic [1:0] {
        ARB_ERR_OVERRUN  = 2'd0,
        ARB_ERR_TIMEOUT  = 2'd1,
        ARB_ERR_SPURIOUS = 2'd2
    } ArbErr_t;

    localparam int ARB_ERR_W = 3;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear and enable.
// MODE 0 saturates at all-ones, any other MODE wraps.
module counter #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (MODE == 0 && count == {WIDTH{1'b1}}) begin
                count <= count;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Round-robin selector: first pending channel strictly after last_grant, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int cand;

    // Scan from the farthest candidate back to the nearest so the nearest pending wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (pending[IDX_W'(cand)]) begin
                grant                = '0;
                grant[IDX_W'(cand)]  = 1'b1;
                grant_idx            = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/compute_ip_arbiter.sv
// Round-robin arbiter sharing one non-pipelined compute IP among NUM_REQ channels,
// with per-channel operand capture, result routing and sticky error detection.
module compute_ip_arbiter
    import compute_ip_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 22,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*DATA_W-1:0] req_in_1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in_2,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_out,
    output logic                      ip_start,
    output logic [DATA_W-1:0]         ip_in_1,
    output logic [DATA_W-1:0]         ip_in_2,
    input  logic                      ip_busy,
    input  logic                      ip_done,
    input  logic [DATA_W-1:0]         ip_out,
    input  logic                      err_clr,
    output logic [ARB_ERR_W-1:0]      err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    // Handshake: req_start/ip_start/ip_done/req_done are single-cycle pulses with no
    // back-pressure; a channel owns one slot, so a start is only legal while its busy is low,
    // and the IP is only started while ip_busy is low.

    ArbState_t                state;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         owner;
    logic [NUM_REQ-1:0]       pending;
    logic [DATA_W-1:0]        op1 [NUM_REQ];
    logic [DATA_W-1:0]        op2 [NUM_REQ];

    logic [NUM_REQ-1:0]       pick_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic [WD_W-1:0]          wd_count;

    logic                     issue;
    logic                     wd_expired;
    logic                     finish;
    logic [NUM_REQ-1:0]       finish_mask;
    logic [NUM_REQ-1:0]       accept;
    logic [ARB_ERR_W-1:0]     err_set;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    counter #(
        .WIDTH (WD_W),
        .MODE  (0)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (issue),
        .en    (state == ARB_WAIT),
        .count (wd_count)
    );

    // A channel whose op finishes this cycle may be re-armed by a start in the same cycle.
    always_comb begin
        issue       = (state == ARB_IDLE) && (|pick_grant) && !ip_busy;
        wd_expired  = (wd_count == WD_W'(TIMEOUT_CYC - 1));
        finish      = (state == ARB_WAIT) && (ip_done || wd_expired);
        finish_mask = finish ? (NUM_REQ'(1) << owner) : '0;
        accept      = req_start & (~pending | finish_mask);
        err_set     = '0;
        err_set[ARB_ERR_OVERRUN]  = |(req_start & pending & ~finish_mask);
        err_set[ARB_ERR_TIMEOUT]  = (state == ARB_WAIT) && !ip_done && wd_expired;
        err_set[ARB_ERR_SPURIOUS] = (state == ARB_IDLE) && ip_done;
    end

    assign req_busy = pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            pending    <= '0;
            req_done   <= '0;
            req_out    <= '0;
            ip_start   <= 1'b0;
            ip_in_1    <= '0;
            ip_in_2    <= '0;
            err        <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                op1[i] <= '0;
                op2[i] <= '0;
            end
        end else begin
            req_done <= '0;
            ip_start <= 1'b0;
            pending  <= (pending & ~finish_mask) | accept;
            err      <= err_clr ? '0 : (err | err_set);

            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    op1[i] <= req_in_1[i*DATA_W +: DATA_W];
                    op2[i] <= req_in_2[i*DATA_W +: DATA_W];
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (issue) begin
                        ip_in_1  <= op1[pick_idx];
                        ip_in_2  <= op2[pick_idx];
                        ip_start <= 1'b1;
                        owner    <= pick_idx;
                        state    <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (ip_done) begin
                        req_out         <= ip_out;
                        req_done[owner] <= 1'b1;
                        last_grant      <= owner;
                        state           <= ARB_IDLE;
                    end else if (wd_expired) begin
                        req_out         <= '0;
                        req_done[owner] <= 1'b1;
                        last_grant      <= owner;
                        state           <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compute_ip_arbiter.sv
// Directed bench for compute_ip_arbiter with a hand-driven IP mock.
module tb_compute_ip_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 22;
    localparam int TO_CYC  = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_start;
    logic [NUM_REQ*DATA_W-1:0] req_in_1;
    logic [NUM_REQ*DATA_W-1:0] req_in_2;
    logic [NUM_REQ-1:0]        req_busy;
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         req_out;
    logic                      ip_start;
    logic [DATA_W-1:0]         ip_in_1;
    logic [DATA_W-1:0]         ip_in_2;
    logic                      ip_busy;
    logic                      ip_done;
    logic [DATA_W-1:0]         ip_out;
    logic                      err_clr;
    logic [2:0]                err;

    int n_tests;
    int n_fail;

    compute_ip_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_start (req_start),
        .req_in_1  (req_in_1),
        .req_in_2  (req_in_2),
        .req_busy  (req_busy),
        .req_done  (req_done),
        .req_out   (req_out),
        .ip_start  (ip_start),
        .ip_in_1   (ip_in_1),
        .ip_in_2   (ip_in_2),
        .ip_busy   (ip_busy),
        .ip_done   (ip_done),
        .ip_out    (ip_out),
        .err_clr   (err_clr),
        .err       (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_start = '0;
        req_in_1  = '0;
        req_in_2  = '0;
        ip_busy   = 1'b0;
        ip_done   = 1'b0;
        ip_out    = '0;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int ch, input int a, input int b);
        req_in_1[ch*DATA_W +: DATA_W] = DATA_W'(a);
        req_in_2[ch*DATA_W +: DATA_W] = DATA_W'(b);
    endtask

    task automatic start(input logic [NUM_REQ-1:0] mask);
        req_start = mask;
        tick();
        req_start = '0;
    endtask

    // Bounded wait for the next ip_start pulse.
    task automatic wait_issue(input string tag);
        int n;
        n = 0;
        tick();
        while (!ip_start && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(ip_start), 32'd1);
    endtask

    // Called in the ip_start cycle; raises ip_done lat cycles later and returns in the req_done cycle.
    task automatic ip_serve(input int lat, input int val, input logic [NUM_REQ-1:0] restart);
        repeat (lat) tick();
        ip_done   = 1'b1;
        ip_out    = DATA_W'(val);
        req_start = restart;
        tick();
        ip_done   = 1'b0;
        req_start = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("rst_req_busy", 32'(req_busy), 32'd0);
        check("rst_req_done", 32'(req_done), 32'd0);
        check("rst_req_out",  32'(req_out),  32'd0);
        check("rst_ip_start", 32'(ip_start), 32'd0);
        check("rst_ip_in_1",  32'(ip_in_1),  32'd0);
        check("rst_err",      32'(err),      32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single op on ch1, 3-cycle IP
        set_op(1, 5, 7);
        start(3'b010);
        check("t1_busy_next", 32'(req_busy), 32'b010);
        check("t1_no_start_t1", 32'(ip_start), 32'd0);
        tick();
        check("t1_ip_start_t2", 32'(ip_start), 32'd1);
        check("t1_ip_in_1", 32'(ip_in_1), 32'd5);
        check("t1_ip_in_2", 32'(ip_in_2), 32'd7);
        ip_serve(3, 12, 3'b000);
        check("t1_req_done", 32'(req_done), 32'b010);
        check("t1_req_out", 32'(req_out), 32'd12);
        tick();
        check("t1_done_pulse", 32'(req_done), 32'd0);
        check("t1_busy_clear", 32'(req_busy), 32'd0);
        check("t1_out_hold", 32'(req_out), 32'd12);

        // 2: contention, two rounds, all three channels at once
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_REQ; c++) set_op(c, 10 + c, 20 + c);
            start(3'b111);
            check("t2_busy_all", 32'(req_busy), 32'b111);
            for (int k = 0; k < NUM_REQ; k++) begin
                wait_issue("t2_issue");
                check("t2_order_in_1", 32'(ip_in_1), 32'(10 + k));
                check("t2_order_in_2", 32'(ip_in_2), 32'(20 + k));
                ip_serve(1, 100 + k, 3'b000);
                check("t2_req_done", 32'(req_done), 32'(1 << k));
                check("t2_req_out", 32'(req_out), 32'(100 + k));
                check("t2_no_b2b", 32'(ip_start), 32'd0);
            end
        end

        // 3: fairness, ch0 re-arms on its own done while ch2 waits
        set_op(0, 30, 0);
        set_op(2, 32, 0);
        start(3'b101);
        wait_issue("t3_issue_a");
        check("t3_first_ch0", 32'(ip_in_1), 32'd30);
        set_op(0, 31, 0);
        ip_serve(1, 200, 3'b001);
        check("t3_done_ch0", 32'(req_done), 32'b001);
        check("t3_busy_kept", 32'(req_busy), 32'b101);
        wait_issue("t3_issue_b");
        check("t3_ch2_next", 32'(ip_in_1), 32'd32);
        ip_serve(1, 201, 3'b000);
        check("t3_done_ch2", 32'(req_done), 32'b100);
        wait_issue("t3_issue_c");
        check("t3_ch0_second", 32'(ip_in_1), 32'd31);
        ip_serve(1, 202, 3'b000);
        check("t3_done_ch0_2", 32'(req_done), 32'b001);
        check("t3_out", 32'(req_out), 32'd202);
        tick();
        check("t3_idle_busy", 32'(req_busy), 32'd0);

        // 4: overrun keeps original operands, err_clr, clear beats same-cycle set
        do_reset();
        set_op(0, 3, 4);
        start(3'b001);
        set_op(0, 9, 9);
        start(3'b001);
        check("t4_ip_start", 32'(ip_start), 32'd1);
        check("t4_ip_in_1", 32'(ip_in_1), 32'd3);
        check("t4_ip_in_2", 32'(ip_in_2), 32'd4);
        check("t4_err_overrun", 32'(err), 32'b001);
        ip_serve(2, 7, 3'b000);
        check("t4_out", 32'(req_out), 32'd7);
        check("t4_err_sticky", 32'(err), 32'b001);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", 32'(err), 32'd0);
        set_op(1, 1, 1);
        start(3'b010);
        err_clr = 1'b1;
        start(3'b010);
        err_clr = 1'b0;
        check("t4_clr_priority", 32'(err), 32'd0);

        // 5: timeout after TO_CYC wait cycles, then a late done is spurious
        do_reset();
        set_op(1, 1, 1);
        start(3'b010);
        wait_issue("t5_issue_a");
        ip_serve(1, 55, 3'b000);
        check("t5_out_55", 32'(req_out), 32'd55);
        set_op(2, 2, 2);
        start(3'b100);
        wait_issue("t5_issue_b");
        repeat (TO_CYC - 1) tick();
        check("t5_not_early", 32'(req_done), 32'd0);
        tick();
        check("t5_to_done", 32'(req_done), 32'b100);
        check("t5_to_out", 32'(req_out), 32'd0);
        check("t5_to_err", 32'(err), 32'b010);
        check("t5_to_busy", 32'(req_busy), 32'd0);
        ip_done = 1'b1;
        ip_out  = DATA_W'(77);
        tick();
        ip_done = 1'b0;
        check("t5_spurious_err", 32'(err), 32'b110);
        check("t5_spurious_no_done", 32'(req_done), 32'd0);
        check("t5_spurious_out", 32'(req_out), 32'd0);

        // 6: ip_busy blocks issue; async reset mid-WAIT
        do_reset();
        ip_busy = 1'b1;
        set_op(1, 17, 18);
        start(3'b010);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_blocked", 32'(ip_start), 32'd0);
        end
        ip_busy = 1'b0;
        tick();
        check("t6_issue", 32'(ip_start), 32'd1);
        check("t6_ip_in_1", 32'(ip_in_1), 32'd17);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(req_busy), 32'd0);
        check("t6_rst_ip_in_1", 32'(ip_in_1), 32'd0);
        check("t6_rst_ip_in_2", 32'(ip_in_2), 32'd0);
        check("t6_rst_done", 32'(req_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_done_after_rst", 32'(req_done), 32'd0);
        end
        ip_done = 1'b1;
        tick();
        ip_done = 1'b0;
        check("t6_late_done_err", 32'(err), 32'b100);
        check("t6_late_done_no_done", 32'(req_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
